tmr_channel_ctrl: RTL and testbench

Control unit for one 8-bit timer channel: selects the count source (internal prescaler taps, external TMCI edges or cascade input), advances and clears TCNT, evaluates compare-match A/B and overflow, drives the TMO compare-match output and maintains the status flags and interrupt requests. Each channel instantiates one copy alongside its two comparators, with the channel register file supplying TCR/TCSR/TCOR values. Cascade ports chain channel 0→1 and channel 2→3.

---
 rtl/tmr_channel_ctrl.sv | 154 +++++++++++++++
 tb/tb_tmr_channel_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_channel_ctrl.sv
// Per-channel control for an 8-bit timer: count-source selection, TCNT advance/clear,
// compare-match and overflow events, TMO output, status flags and interrupt requests.
module tmr_channel_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int PSC_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_WIDTH-1:0] tcr,
  input  logic [3:0]           tcsr_os,
  input  logic [BIT_WIDTH-1:0] tcora,
  input  logic [BIT_WIDTH-1:0] tcorb,
  input  logic                 tcnt_wr,
  input  logic [BIT_WIDTH-1:0] tcnt_wdata,
  input  logic [2:0]           flag_clr,
  input  logic                 tmci,
  input  logic                 tmri,
  input  logic                 cascade_in,
  output logic [BIT_WIDTH-1:0] tcnt,
  output logic                 tmo,
  output logic [2:0]           flags,
  output logic [2:0]           irq,
  output logic                 ovf_pulse,
  output logic                 cma_pulse
);

  localparam logic [2:0] CKS_STOP  = 3'b000;
  localparam logic [2:0] CKS_P8    = 3'b001;
  localparam logic [2:0] CKS_P64   = 3'b010;
  localparam logic [2:0] CKS_PTOP  = 3'b011;
  localparam logic [2:0] CKS_CASC  = 3'b100;
  localparam logic [2:0] CKS_RISE  = 3'b101;
  localparam logic [2:0] CKS_FALL  = 3'b110;
  localparam logic [2:0] CKS_BOTH  = 3'b111;

  logic [PSC_W-1:0]     psc_r;
  logic                 tmci_s1_r, tmci_s2_r, tmci_prev_r;
  logic                 tmri_s1_r, tmri_s2_r, tmri_prev_r, tmri_rise_r;
  logic [BIT_WIDTH-1:0] tcnt_r, tcnt_nxt_s;
  logic                 tmo_r, tmo_nxt_s;
  logic [2:0]           flags_r;
  logic                 ovf_pulse_r, cma_pulse_r;
  logic                 tick_s, match_a_s, match_b_s, mclr_s, tmri_clr_s, ovf_s;
  logic                 tmci_rise_s, tmci_fall_s;
  logic [2:0]           cks_s;
  logic [1:0]           cclr_s, act_a_s, act_b_s, act_s;

  assign cks_s       = tcr[2:0];
  assign cclr_s      = tcr[4:3];
  assign tmci_rise_s = tmci_s2_r & ~tmci_prev_r;
  assign tmci_fall_s = ~tmci_s2_r & tmci_prev_r;

  // Prescaler plus synchronizers for the asynchronous TMCI/TMRI pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_r       <= {PSC_W{1'b0}};
      tmci_s1_r   <= 1'b0;
      tmci_s2_r   <= 1'b0;
      tmci_prev_r <= 1'b0;
      tmri_s1_r   <= 1'b0;
      tmri_s2_r   <= 1'b0;
      tmri_prev_r <= 1'b0;
      tmri_rise_r <= 1'b0;
    end else begin
      psc_r       <= psc_r + {{(PSC_W-1){1'b0}}, 1'b1};
      tmci_s1_r   <= tmci;
      tmci_s2_r   <= tmci_s1_r;
      tmci_prev_r <= tmci_s2_r;
      tmri_s1_r   <= tmri;
      tmri_s2_r   <= tmri_s1_r;
      tmri_prev_r <= tmri_s2_r;
      tmri_rise_r <= tmri_s2_r & ~tmri_prev_r;
    end
  end

  // Count-source selection.
  always_comb begin
    tick_s = 1'b0;
    case (cks_s)
      CKS_STOP: tick_s = 1'b0;
      CKS_P8:   tick_s = &psc_r[2:0];
      CKS_P64:  tick_s = &psc_r[5:0];
      CKS_PTOP: tick_s = &psc_r;
      CKS_CASC: tick_s = cascade_in;
      CKS_RISE: tick_s = tmci_rise_s;
      CKS_FALL: tick_s = tmci_fall_s;
      CKS_BOTH: tick_s = tmci_rise_s | tmci_fall_s;
      default:  tick_s = 1'b0;
    endcase
  end

  // A CPU write to TCNT swallows the tick, so no event can fire in that cycle.
  assign match_a_s  = tick_s & ~tcnt_wr & (tcnt_r == tcora);
  assign match_b_s  = tick_s & ~tcnt_wr & (tcnt_r == tcorb);
  assign tmri_clr_s = (cclr_s == 2'b11) & tmri_rise_r;
  assign mclr_s     = ((cclr_s == 2'b01) & match_a_s) | ((cclr_s == 2'b10) & match_b_s);
  assign ovf_s      = tick_s & ~tcnt_wr & (&tcnt_r) & ~mclr_s & ~tmri_clr_s;

  // Next counter value in priority order.
  always_comb begin
    tcnt_nxt_s = tcnt_r;
    if (tcnt_wr) begin
      tcnt_nxt_s = tcnt_wdata;
    end else if (tmri_clr_s || mclr_s) begin
      tcnt_nxt_s = {BIT_WIDTH{1'b0}};
    end else if (tick_s) begin
      tcnt_nxt_s = tcnt_r + {{(BIT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      tcnt_nxt_s = tcnt_r;
    end
  end

  // Action codes are ordered by priority, so the larger active code wins.
  assign act_a_s = match_a_s ? tcsr_os[1:0] : 2'b00;
  assign act_b_s = match_b_s ? tcsr_os[3:2] : 2'b00;
  assign act_s   = (act_a_s > act_b_s) ? act_a_s : act_b_s;

  // TMO output resolution.
  always_comb begin
    tmo_nxt_s = tmo_r;
    case (act_s)
      2'b00:   tmo_nxt_s = tmo_r;
      2'b01:   tmo_nxt_s = 1'b0;
      2'b10:   tmo_nxt_s = 1'b1;
      2'b11:   tmo_nxt_s = ~tmo_r;
      default: tmo_nxt_s = tmo_r;
    endcase
  end

  // Channel state: counter, output, flags (set beats clear) and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r      <= {BIT_WIDTH{1'b0}};
      tmo_r       <= 1'b0;
      flags_r     <= 3'b000;
      ovf_pulse_r <= 1'b0;
      cma_pulse_r <= 1'b0;
    end else begin
      tcnt_r      <= tcnt_nxt_s;
      tmo_r       <= tmo_nxt_s;
      flags_r     <= (flags_r & ~flag_clr) | {match_b_s, match_a_s, ovf_s};
      ovf_pulse_r <= ovf_s;
      cma_pulse_r <= match_a_s;
    end
  end

  assign tcnt      = tcnt_r;
  assign tmo       = tmo_r;
  assign flags     = flags_r;
  assign irq       = flags_r & tcr[7:5];
  assign ovf_pulse = ovf_pulse_r;
  assign cma_pulse = cma_pulse_r;

endmodule

// File: tb/tb_tmr_channel_ctrl.sv
// Scoreboard bench for tmr_channel_ctrl: stimulus queues expected snapshots tagged with
// the clock edge they belong to, a negedge monitor pops and compares them.
module tb_tmr_channel_ctrl;

  logic       clk, rst;
  logic [7:0] tcr, tcora, tcorb, tcnt_wdata, tcnt;
  logic [3:0] tcsr_os;
  logic       tcnt_wr, tmci, tmri, cascade_in, tmo, ovf_pulse, cma_pulse;
  logic [2:0] flag_clr, flags, irq;

  tmr_channel_ctrl #(.BIT_WIDTH(8), .PSC_W(13)) dut (
    .clk(clk), .rst(rst), .tcr(tcr), .tcsr_os(tcsr_os), .tcora(tcora), .tcorb(tcorb),
    .tcnt_wr(tcnt_wr), .tcnt_wdata(tcnt_wdata), .flag_clr(flag_clr), .tmci(tmci),
    .tmri(tmri), .cascade_in(cascade_in), .tcnt(tcnt), .tmo(tmo), .flags(flags),
    .irq(irq), .ovf_pulse(ovf_pulse), .cma_pulse(cma_pulse)
  );

  typedef struct packed {
    int          cyc;
    logic [16:0] val;   // {tcnt, tmo, flags, irq, ovf_pulse, cma_pulse}
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    cyc = 0;
  int    base = 0;
  int    n_vec = 0;
  int    n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued snapshot that belongs to the edge just taken.
  always @(negedge clk) begin
    int i;
    logic [16:0] act;
    act = {tcnt, tmo, flags, irq, ovf_pulse, cma_pulse};
    i = 0;
    while (i < q_exp.size()) begin
      if (q_exp[i].cyc == cyc) begin
        n_vec = n_vec + 1;
        if (act !== q_exp[i].val) begin
          n_err = n_err + 1;
          $display("FAIL %s: got tcnt/tmo/flags/irq/ovfp/cmap=%h/%b/%b/%b/%b/%b want %h/%b/%b/%b/%b/%b",
                   q_name[i], act[16:9], act[8], act[7:5], act[4:2], act[1], act[0],
                   q_exp[i].val[16:9], q_exp[i].val[8], q_exp[i].val[7:5],
                   q_exp[i].val[4:2], q_exp[i].val[1], q_exp[i].val[0]);
        end
        q_exp.delete(i);
        q_name.delete(i);
      end else begin
        i = i + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic exp_at(input int o, input string nm, input logic [7:0] t, input logic tm,
                        input logic [2:0] f, input logic [2:0] iq, input logic op, input logic cp);
    exp_t e;
    e.cyc = base + o;
    e.val = {t, tm, f, iq, op, cp};
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  // Advance to 2 time units after edge base+o.
  task automatic at(input int o);
    while (cyc < base + o) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic [7:0] cr, input logic [3:0] os,
                          input logic [7:0] ra, input logic [7:0] rb);
    rst = 1'b1; tcr = cr; tcsr_os = os; tcora = ra; tcorb = rb;
    tcnt_wr = 1'b0; tcnt_wdata = 8'h00; flag_clr = 3'b000;
    tmci = 1'b0; tmri = 1'b0; cascade_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
    base = cyc;
  endtask

  initial begin
    // Reset state, then CKS=001 CCLR=00 OVIE=1: overflow, flag clear, write-vs-tick.
    do_reset(8'h21, 4'b0000, 8'h80, 8'h80);
    exp_at(0,  "reset_state",   8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(7,  "t1_before_tick",8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(8,  "t1_first_tick", 8'h01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(16, "t1_second_tick",8'h02, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(40, "t1_wrap_ovf",   8'h00, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0);
    exp_at(41, "t1_ovfp_low",   8'h00, 1'b0, 3'b001, 3'b001, 1'b0, 1'b0);
    exp_at(42, "t1_flag_clr",   8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(48, "t1_set_wins",   8'h00, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0);
    exp_at(56, "t1_wr_beats_tick", 8'hFF, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(64, "t1_wrap_again", 8'h00, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0);
    at(17);
    n_vec = n_vec + 1;
    if (tcnt !== 8'h02) begin
      n_err = n_err + 1;
      $display("FAIL t1_inline_tcnt17: got %h want 02", tcnt);
    end
    tcnt_wr = 1'b1; tcnt_wdata = 8'hFD;
    at(18); tcnt_wr = 1'b0;
    at(41);
    n_vec = n_vec + 1;
    if (flags !== 3'b001) begin
      n_err = n_err + 1;
      $display("FAIL t1_inline_ovf_set: got flags %b want 001", flags);
    end
    flag_clr = 3'b001;
    at(42);
    n_vec = n_vec + 1;
    if (flags !== 3'b000) begin
      n_err = n_err + 1;
      $display("FAIL t1_inline_ovf_clr: got flags %b want 000", flags);
    end
    flag_clr = 3'b000; tcnt_wr = 1'b1; tcnt_wdata = 8'hFF;
    at(43); tcnt_wr = 1'b0;
    at(47); flag_clr = 3'b001;
    at(48); flag_clr = 3'b000;
    at(49); tcnt_wr = 1'b1; tcnt_wdata = 8'hFF;
    at(50); tcnt_wr = 1'b0;
    at(55); tcnt_wr = 1'b1; tcnt_wdata = 8'hFF; flag_clr = 3'b001;
    at(56); tcnt_wr = 1'b0; flag_clr = 3'b000;
    at(66);

    // CCLR=01 with tcora=05, OS_A=toggle, CMIEA=1.
    do_reset(8'h49, 4'b0011, 8'h05, 8'h80);
    exp_at(40, "t2_count_five", 8'h05, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(48, "t2_match_clear",8'h00, 1'b1, 3'b010, 3'b010, 1'b0, 1'b1);
    exp_at(49, "t2_cmap_low",   8'h00, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
    exp_at(88, "t2_count_five2",8'h05, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
    exp_at(96, "t2_match_again",8'h00, 1'b0, 3'b010, 3'b010, 1'b0, 1'b1);
    at(98);
    n_vec = n_vec + 1;
    if ((tcnt !== 8'h00) || (tmo !== 1'b0)) begin
      n_err = n_err + 1;
      $display("FAIL t2_inline_end: got tcnt %h tmo %b want 00/0", tcnt, tmo);
    end

    // tcora == tcorb, OS_A=drive 0, OS_B=toggle: toggle wins; then mid-count reset.
    do_reset(8'h01, 4'b1101, 8'h03, 8'h03);
    exp_at(24, "t3_count_three",8'h03, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(32, "t3_dual_match", 8'h04, 1'b1, 3'b110, 3'b000, 1'b0, 1'b1);
    exp_at(35, "t3_mid_reset",  8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    at(34); rst = 1'b1;
    at(35); rst = 1'b0;
    at(36);
    n_vec = n_vec + 1;
    if (tcnt !== 8'h00) begin
      n_err = n_err + 1;
      $display("FAIL t3_inline_after_reset: got tcnt %h want 00", tcnt);
    end

    // TMCI falling edges (CKS=110), then both edges (CKS=111).
    do_reset(8'h06, 4'b0000, 8'h80, 8'h80);
    exp_at(10, "t4_rise_ignored", 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(12, "t4_fall_latency", 8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(13, "t4_fall_count",   8'h01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(15, "t4_fall_once",    8'h01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(19, "t4_both_latency", 8'h01, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(20, "t4_both_rise",    8'h02, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(24, "t4_both_latency2",8'h02, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(25, "t4_both_fall",    8'h03, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(27, "t4_both_once",    8'h03, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    at(2);  tmci = 1'b1;
    at(10); tmci = 1'b0;
    at(15); tcr = 8'h07;
    at(17); tmci = 1'b1;
    at(22); tmci = 1'b0;
    at(28);

    // CCLR=11, counter stopped at 0x40: TMRI rising clears, falling does not.
    do_reset(8'h18, 4'b0000, 8'h80, 8'h80);
    exp_at(2,  "t5_load",         8'h40, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(7,  "t5_tmri_latency", 8'h40, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(8,  "t5_tmri_clear",   8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(11, "t5_reload",       8'h40, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    exp_at(20, "t5_fall_ignored", 8'h40, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
    at(1);  tcnt_wr = 1'b1; tcnt_wdata = 8'h40;
    at(2);
    n_vec = n_vec + 1;
    if (tcnt !== 8'h40) begin
      n_err = n_err + 1;
      $display("FAIL t5_inline_load: got tcnt %h want 40", tcnt);
    end
    tcnt_wr = 1'b0;
    at(4);  tmri = 1'b1;
    at(10);
    n_vec = n_vec + 1;
    if (tcnt !== 8'h00) begin
      n_err = n_err + 1;
      $display("FAIL t5_inline_cleared: got tcnt %h want 00", tcnt);
    end
    tcnt_wr = 1'b1; tcnt_wdata = 8'h40;
    at(11); tcnt_wr = 1'b0;
    at(14); tmri = 1'b0;
    at(22);

    while (q_exp.size() > 0) begin
      n_vec = n_vec + 1;
      n_err = n_err + 1;
      $display("FAIL %s: never compared, scheduled edge %0d, now %0d", q_name[0], q_exp[0].cyc, cyc);
      q_exp.delete(0);
      q_name.delete(0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
